// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data RAM between the CPU
// load/store path and an external requester, with EXT starvation relief.
module data_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_EXT_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int SW = $clog2(MAX_EXT_WAIT + 1);
    localparam logic [LW-1:0] LAT_LAST   = LW'(READ_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_EXT_WAIT);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    logic [1:0]            state_q, state_d;
    logic                  own_q, own_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
    logic                  grant_ext;
    logic                  in_access;

    assign grant_ext = ext_req & (~cpu_req | (starve_q == STARVE_MAX));

    // Next-state: arbitration in IDLE, strobe timing in ACCESS, ack in RESP.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req | ext_req) begin
                    state_d = S_ACCESS;
                    own_d   = grant_ext;
                    we_d    = grant_ext ? ext_we : cpu_we;
                    addr_d  = (grant_ext ? ext_addr : cpu_addr) & WORD_MASK;
                    wdata_d = grant_ext ? ext_wdata : cpu_wdata;
                    lat_d   = '0;
                    if (grant_ext)
                        starve_d = '0;
                    else if (ext_req && starve_q != STARVE_MAX)
                        starve_d = starve_q + 1'b1;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else if (lat_q == LAT_LAST) begin
                    state_d = S_RESP;
                    if (own_q)
                        ext_rdata_d = mem_rdata;
                    else
                        cpu_rdata_d = mem_rdata;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            own_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    assign in_access = (state_q == S_ACCESS);
    assign mem_we    = in_access & we_q;
    assign mem_re    = in_access & ~we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign cpu_ack   = (state_q == S_RESP) & ~own_q;
    assign ext_ack   = (state_q == S_RESP) & own_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign owner     = own_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed checks of the data memory arbiter
// with a RAM model (latency 1) and a counting read source (latency 3).
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    // Instance A: READ_LATENCY = 1
    logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ext_ack, mem_we, mem_re, owner;

    // Instance B: READ_LATENCY = 3
    logic        cpu_req3 = 0, cpu_we3 = 0, ext_req3 = 0, ext_we3 = 0;
    logic [31:0] cpu_addr3 = 0, cpu_wdata3 = 0, ext_addr3 = 0, ext_wdata3 = 0;
    logic [31:0] cpu_rdata3, ext_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        cpu_ack3, cpu_stall3, ext_ack3, mem_we3, mem_re3, owner3;

    logic [31:0] ram [0:63];
    logic [31:0] rcnt3;

    always #5 clk = ~clk;

    data_memory_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .owner(owner)
    );

    data_memory_arbiter #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3),
        .cpu_wdata(cpu_wdata3), .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
        .cpu_stall(cpu_stall3),
        .ext_req(ext_req3), .ext_we(ext_we3), .ext_addr(ext_addr3),
        .ext_wdata(ext_wdata3), .ext_rdata(ext_rdata3), .ext_ack(ext_ack3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3),
        .mem_re(mem_re3), .mem_rdata(mem_rdata3), .owner(owner3)
    );

    // RAM model for instance A, combinational read
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

    // Read source for instance B: value tags which mem_re cycle it is
    assign mem_rdata3 = 32'hCAFE0000 | rcnt3;
    always @(posedge clk)
        if (reset) rcnt3 <= 0;
        else if (mem_re3) rcnt3 <= rcnt3 + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    int  acks;
    bit  got;
    bit  bad3;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        nxt; nxt;
        @(negedge clk);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ext_ack", ext_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_owner", owner, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        nxt;
        reset = 0;

        // T1 store then load
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_stall_N", cpu_stall, 1);
        check("t1_we_N", mem_we, 0);
        nxt; @(negedge clk);
        check("t1_we_N1", mem_we, 1);
        check("t1_addr_N1", mem_addr, 32'h10);
        check("t1_wdata_N1", mem_wdata, 32'hDEADBEEF);
        check("t1_ack_N1", cpu_ack, 0);
        nxt; @(negedge clk);
        check("t1_ack_N2", cpu_ack, 1);
        check("t1_we_N2", mem_we, 0);
        check("t1_stall_N2", cpu_stall, 0);
        nxt;
        cpu_req = 0;
        @(negedge clk);
        check("t1_idle_ack", cpu_ack, 0);
        nxt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        nxt; @(negedge clk);
        check("t1_re_N1", mem_re, 1);
        check("t1_rack_N1", cpu_ack, 0);
        nxt; @(negedge clk);
        check("t1_rack_N2", cpu_ack, 1);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_rstall_N2", cpu_stall, 0);
        nxt;
        cpu_req = 0;
        nxt;

        // T2 simultaneous requests, CPU first
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1;
        ext_req = 1; ext_we = 1; ext_addr = 32'h24; ext_wdata = 32'h2;
        nxt; @(negedge clk);
        check("t2_owner_cpu", owner, 0);
        check("t2_addr_cpu", mem_addr, 32'h20);
        nxt; @(negedge clk);
        check("t2_cpu_ack", cpu_ack, 1);
        check("t2_ext_ack0", ext_ack, 0);
        nxt;
        cpu_req = 0;
        nxt; @(negedge clk);
        check("t2_owner_ext", owner, 1);
        check("t2_addr_ext", mem_addr, 32'h24);
        check("t2_wdata_ext", mem_wdata, 32'h2);
        nxt; @(negedge clk);
        check("t2_ext_ack", ext_ack, 1);
        nxt;
        ext_req = 0;

        // T3 starvation relief after 4 CPU grants
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hA5;
        ext_req = 1; ext_we = 0; ext_addr = 32'h10;
        acks = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ext_ack) begin
                got = 1;
                check("t3_ext_rdata", ext_rdata, 32'hDEADBEEF);
                check("t3_owner", owner, 1);
            end else if (cpu_ack) begin
                acks++;
            end
        end
        check("t3_ext_seen", got, 1);
        check("t3_cpu_acks", acks, 4);
        nxt;
        cpu_req = 0; ext_req = 0;

        // T4 three-cycle read on instance B
        bad3 = 0;
        ext_req3 = 1; ext_we3 = 0; ext_addr3 = 32'h40;
        @(negedge clk);
        check("t4_re_N", mem_re3, 0);
        for (int i = 1; i <= 3; i++) begin
            nxt; @(negedge clk);
            check("t4_re_on", mem_re3, 1);
            check("t4_addr", mem_addr3, 32'h40);
            check("t4_ack_early", ext_ack3, 0);
            bad3 |= cpu_ack3;
        end
        nxt; @(negedge clk);
        check("t4_ack_N4", ext_ack3, 1);
        check("t4_re_off", mem_re3, 0);
        check("t4_rdata", ext_rdata3, 32'hCAFE0002);
        bad3 |= cpu_ack3;
        nxt;
        ext_req3 = 0;
        @(negedge clk);
        bad3 |= cpu_ack3;
        check("t4_no_cpu_ack", bad3, 0);

        // T6 misaligned store, request dropped mid-access
        nxt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h13; cpu_wdata = 32'h55;
        nxt;
        cpu_req = 0;
        @(negedge clk);
        check("t6_addr", mem_addr, 32'h10);
        check("t6_we", mem_we, 1);
        nxt; @(negedge clk);
        check("t6_ack", cpu_ack, 1);
        check("t6_ram", ram[4], 32'h55);
        nxt;

        // T5 reset during a write ACCESS with starvation count at max
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h77;
        ext_req = 1; ext_we = 0; ext_addr = 32'h0;
        acks = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            if (acks == 3 && mem_we) got = 1;
        end
        check("t5_reach_access", got, 1);
        reset = 1;
        nxt; @(negedge clk);
        check("t5_we", mem_we, 0);
        check("t5_cpu_ack", cpu_ack, 0);
        check("t5_ext_ack", ext_ack, 0);
        check("t5_addr", mem_addr, 0);
        check("t5_owner", owner, 0);
        check("t5_cpu_rdata", cpu_rdata, 0);
        check("t5_ext_rdata", ext_rdata, 0);
        nxt;
        reset = 0;
        @(negedge clk);
        check("t5_idle_ack", cpu_ack | ext_ack, 0);
        nxt; @(negedge clk);
        check("t5_regrant_cpu", owner, 0);
        check("t5_regrant_addr", mem_addr, 32'h8);
        nxt; @(negedge clk);
        check("t5_cpu_ack2", cpu_ack, 1);
        nxt;
        cpu_req = 0; ext_req = 0;
        nxt; nxt; nxt;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
